vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 173 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-strobe divider plus horizontal/vertical raster
// counters. All visible outputs are registered together on the pixel strobe
// so that x/y, the sync pulses and the start markers never skew against
// each other.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 4,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 10,
  parameter int FW       = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic [FW-1:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // A divide-by-one still needs a one-bit counter that simply stays at zero.
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] LP_DIV_LAST = DW'(CLK_DIV - 1);

  localparam logic [CW-1:0] LP_H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] LP_H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] LP_HS_BEGIN = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] LP_HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [CW-1:0] LP_V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] LP_V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] LP_VS_BEGIN = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] LP_VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] r_div;
  logic [CW-1:0] r_h;
  logic [CW-1:0] r_v;

  logic          r_pix_en;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_active;
  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;
  logic          r_line_start;
  logic          r_frame_start;
  logic [FW-1:0] r_frame_count;
  logic          r_first_frame;

  logic w_tick;
  logic w_h_wrap;
  logic w_v_wrap;
  logic w_origin;
  logic w_active;
  logic w_hs_on;
  logic w_vs_on;

  // The tick is the clk edge that produces the pixel strobe; counters
  // advance on it and the outputs capture the pre-advance position.
  assign w_tick   = enable && (r_div == LP_DIV_LAST);
  assign w_h_wrap = (r_h == LP_H_LAST);
  assign w_v_wrap = (r_v == LP_V_LAST);
  assign w_origin = (r_h == '0) && (r_v == '0);

  assign w_active = (r_h < LP_H_ACT) && (r_v < LP_V_ACT);
  assign w_hs_on  = (r_h >= LP_HS_BEGIN) && (r_h < LP_HS_END);
  assign w_vs_on  = (r_v >= LP_VS_BEGIN) && (r_v < LP_VS_END);

  // Clock divider and raster position; disabling parks everything at origin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= '0;
      r_h   <= '0;
      r_v   <= '0;
    end else if (!enable) begin
      r_div <= '0;
      r_h   <= '0;
      r_v   <= '0;
    end else if (w_tick) begin
      r_div <= '0;
      if (w_h_wrap) begin
        r_h <= '0;
        r_v <= w_v_wrap ? '0 : r_v + CW'(1);
      end else begin
        r_h <= r_h + CW'(1);
      end
    end else begin
      r_div <= r_div + DW'(1);
    end
  end

  // Registered outputs: all update together on the tick and hold otherwise,
  // except the one-clk pulses which drop on the following clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pix_en      <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_active      <= 1'b0;
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (!enable) begin
      r_pix_en      <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_active      <= 1'b0;
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (w_tick) begin
      r_pix_en      <= 1'b1;
      r_x           <= r_h;
      r_y           <= r_v;
      r_active      <= w_active;
      r_hsync       <= w_hs_on ? HS_POL : ~HS_POL;
      r_vsync       <= w_vs_on ? VS_POL : ~VS_POL;
      r_line_start  <= (r_h == '0);
      r_frame_start <= w_origin;
    end else begin
      r_pix_en      <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  // Completed-frame counter: the first frame start after reset or a
  // re-enable only arms the counter, so aborted frames are never counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_count <= '0;
      r_first_frame <= 1'b1;
    end else if (!enable) begin
      r_first_frame <= 1'b1;
    end else if (w_tick && w_origin) begin
      if (r_first_frame) begin
        r_first_frame <= 1'b0;
      end else begin
        r_frame_count <= r_frame_count + FW'(1);
      end
    end
  end

  assign pix_en      = r_pix_en;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign active      = r_active;
  assign x           = r_x;
  assign y           = r_y;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen using a small 15x8 raster. Instance A
// runs with a divide-by-two pixel clock and active-low syncs, instance B
// with divide-by-one and active-high syncs; the same directed sequence is
// applied to each in turn while the other is parked in reset.
module tb_vga_timing_gen;

  logic clk = 1'b0;

  logic rstA, enA, rstB, enB;

  logic       pixA, hsA, vsA, actA, lsA, fsA;
  logic [3:0] xA, yA, fcA;
  logic       pixB, hsB, vsB, actB, lsB, fsB;
  logic [3:0] xB, yB, fcB;

  logic       sPix, sHs, sVs, sAct, sLs, sFs;
  logic [3:0] sX, sY, sFc;

  logic cfgB;
  logic pol;
  logic nPol;
  int   divN;
  int   ex;
  int   ey;
  int   efc;
  logic sawFifteen;
  logic sawZeroAfterWrap;

  int nChecks;
  int nErrors;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(2), .HS_POL(1'b0), .VS_POL(1'b0), .CW(4), .FW(4)
  ) dutA (
    .clk(clk), .reset(rstA), .enable(enA),
    .pix_en(pixA), .hsync(hsA), .vsync(vsA), .active(actA),
    .x(xA), .y(yA), .line_start(lsA), .frame_start(fsA),
    .frame_count(fcA)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(1), .HS_POL(1'b1), .VS_POL(1'b1), .CW(4), .FW(4)
  ) dutB (
    .clk(clk), .reset(rstB), .enable(enB),
    .pix_en(pixB), .hsync(hsB), .vsync(vsB), .active(actB),
    .x(xB), .y(yB), .line_start(lsB), .frame_start(fsB),
    .frame_count(fcB)
  );

  assign sPix = cfgB ? pixB : pixA;
  assign sHs  = cfgB ? hsB  : hsA;
  assign sVs  = cfgB ? vsB  : vsA;
  assign sAct = cfgB ? actB : actA;
  assign sLs  = cfgB ? lsB  : lsA;
  assign sFs  = cfgB ? fsB  : fsA;
  assign sX   = cfgB ? xB   : xA;
  assign sY   = cfgB ? yB   : yA;
  assign sFc  = cfgB ? fcB  : fcA;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    assert (got === exp) else begin
      nErrors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic setCtl(input logic r, input logic e);
    if (cfgB) begin
      rstB = r;
      enB  = e;
    end else begin
      rstA = r;
      enA  = e;
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".pix_en"}, sPix, 0);
    checkOutput({tag, ".x"}, sX, 0);
    checkOutput({tag, ".y"}, sY, 0);
    checkOutput({tag, ".active"}, sAct, 0);
    checkOutput({tag, ".line_start"}, sLs, 0);
    checkOutput({tag, ".frame_start"}, sFs, 0);
    checkOutput({tag, ".hsync"}, sHs, nPol);
    checkOutput({tag, ".vsync"}, sVs, nPol);
    checkOutput({tag, ".frame_count"}, sFc, efc);
  endtask

  // Expected values for the small raster: visible 0..7 x 0..3,
  // hsync window x=10..12, vsync window y=5..6.
  task automatic checkPixel(input string tag);
    logic expAct, expHs, expVs, expLs, expFs;
    expAct = (ex < 8) && (ey < 4);
    expHs  = (ex >= 10 && ex <= 12) ? pol : nPol;
    expVs  = (ey >= 5 && ey <= 6) ? pol : nPol;
    expLs  = (ex == 0);
    expFs  = (ex == 0) && (ey == 0);
    checkOutput({tag, ".x"}, sX, ex);
    checkOutput({tag, ".y"}, sY, ey);
    checkOutput({tag, ".active"}, sAct, expAct);
    checkOutput({tag, ".hsync"}, sHs, expHs);
    checkOutput({tag, ".vsync"}, sVs, expVs);
    checkOutput({tag, ".line_start"}, sLs, expLs);
    checkOutput({tag, ".frame_start"}, sFs, expFs);
    checkOutput({tag, ".frame_count"}, sFc, efc);
  endtask

  // First strobe after reset release or enable rise: exactly divN clks later, at origin.
  task automatic startUp(input string tag);
    for (int k = 1; k <= divN; k++) begin
      step();
      checkOutput({tag, ".latency"}, sPix, (k == divN));
    end
    ex = 0;
    ey = 0;
    checkPixel(tag);
  endtask

  task automatic advancePix(input string tag);
    for (int k = 1; k <= divN; k++) begin
      step();
      checkOutput({tag, ".cadence"}, sPix, (k == divN));
      if (k < divN) checkOutput({tag, ".holdX"}, sX, ex);
    end
    ex++;
    if (ex == 15) begin
      ex = 0;
      ey++;
      if (ey == 8) ey = 0;
    end
    if (ex == 0 && ey == 0) efc = (efc + 1) % 16;
    checkPixel(tag);
    if (sFc == 4'd15) sawFifteen = 1'b1;
    if (sawFifteen && sFc == 4'd0) sawZeroAfterWrap = 1'b1;
  endtask

  // Full directed sequence against the currently selected instance.
  task automatic applyStimulus(input logic useB);
    cfgB = useB;
    divN = useB ? 1 : 2;
    pol  = useB;
    nPol = ~useB;
    efc  = 0;
    sawFifteen = 1'b0;
    sawZeroAfterWrap = 1'b0;
    $display("[TB] config %s: CLK_DIV=%0d sync polarity=%0d", useB ? "B" : "A", divN, pol);

    setCtl(1'b1, 1'b1);
    step();
    step();
    checkIdle("resetState");

    setCtl(1'b0, 1'b1);
    startUp("firstStrobe");

    for (int i = 0; i < 15; i++) advancePix("line");
    checkOutput("yAfterLine", sY, 1);

    for (int i = 0; i < 2025; i++) advancePix("frames");
    checkOutput("fcReached15", sawFifteen, 1);
    checkOutput("fcWrappedTo0", sawZeroAfterWrap, 1);
    checkOutput("fcAfterWrap", sFc, 1);

    for (int i = 0; i < 35; i++) advancePix("toEnDrop");
    checkOutput("enDropAtX", sX, 5);
    checkOutput("enDropAtY", sY, 2);
    setCtl(1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step();
      checkIdle("enableLow");
    end
    setCtl(1'b0, 1'b1);
    startUp("reEnable");
    checkOutput("fcKeptOnReEnable", sFc, 1);

    for (int i = 0; i < 99; i++) advancePix("toReset");
    checkOutput("resetAtX", sX, 9);
    checkOutput("resetAtY", sY, 6);
    setCtl(1'b1, 1'b1);
    efc = 0;
    #1;
    checkIdle("resetAsync");
    step();
    checkIdle("resetHeld");
    setCtl(1'b0, 1'b1);
    startUp("resetRecover");
    for (int i = 0; i < 20; i++) advancePix("afterRecover");

    setCtl(1'b1, 1'b0);
  endtask

  initial begin
    rstA = 1'b1;
    enA  = 1'b0;
    rstB = 1'b1;
    enB  = 1'b0;
    cfgB = 1'b0;
    pol  = 1'b0;
    nPol = 1'b1;
    divN = 2;
    ex   = 0;
    ey   = 0;
    efc  = 0;
    sawFifteen = 1'b0;
    sawZeroAfterWrap = 1'b0;
    nChecks = 0;
    nErrors = 0;

    applyStimulus(1'b0);
    applyStimulus(1'b1);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
